// File: rtl/btn_step_ctrl_pkg.sv
// Shared types and constants for the button/step controller.
package btn_step_ctrl_pkg;

  localparam int AW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RPT  = 2'b10
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/btn_step_ctrl_edge_rise.sv
// One-flop rising-edge detector; combinational pulse, registered history.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  // Stores "was low last cycle" so a clear history never fakes an edge
  // for a button already held when reset releases.
  logic r_was_low;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_was_low <= 1'b0;
    else      r_was_low <= ~level;
  end

  assign pulse = level & r_was_low;

endmodule

// File: rtl/btn_step_ctrl.sv
// Button front end: CPU clock-enable (run/step) and debug address pointer with inc/dec.
// Define BTN_AUTO_REPEAT_EN to add hold-to-auto-repeat (WAIT/RPT states, counter).
module btn_step_ctrl
  import btn_step_ctrl_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int HOLD = 50000000,
  parameter int RPT  = 10000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          inc,
  input  logic          dec,
  output logic          cpu_en,
  output logic [AW-1:0] addr,
  output logic          addr_chg
);

  if (HOLD < 2 || RPT < 2) begin : g_param_chk
    $error("btn_step_ctrl: HOLD and RPT must both be >= 2");
  end

  logic          w_step_rise;
  logic          w_inc_rise;
  logic          w_dec_rise;
  logic          r_cpu_en;
  logic [AW-1:0] r_addr;
  logic          r_stepped;
  logic          r_addr_chg;

  edge_rise u_step_edge (.clk(clk), .rst(rst), .level(step), .pulse(w_step_rise));
  edge_rise u_inc_edge  (.clk(clk), .rst(rst), .level(inc),  .pulse(w_inc_rise));
  edge_rise u_dec_edge  (.clk(clk), .rst(rst), .level(dec),  .pulse(w_dec_rise));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cpu_en <= 1'b0;
    else      r_cpu_en <= run | w_step_rise;
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int CNT_MAX = (HOLD > RPT) ? HOLD : RPT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT - 1);

  state_e        r_state;
  dir_e          r_dir;
  logic [CW-1:0] r_cnt;
  logic          w_held;
  logic          w_opp;

  assign w_held = (r_dir == DIR_UP) ? inc : dec;
  assign w_opp  = (r_dir == DIR_UP) ? dec : inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_UP;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_stepped <= 1'b0;
    end else begin
      r_stepped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_inc_rise && !dec) begin
            r_addr    <= r_addr + 1'b1;
            r_dir     <= DIR_UP;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
            r_stepped <= 1'b1;
          end else if (w_dec_rise && !inc) begin
            r_addr    <= r_addr - 1'b1;
            r_dir     <= DIR_DN;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
            r_stepped <= 1'b1;
          end
        end
        ST_WAIT, ST_RPT: begin
          // Release or a conflicting press aborts; only a fresh edge restarts.
          if (!w_held || w_opp) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == ((r_state == ST_WAIT) ? HOLD_LAST : RPT_LAST)) begin
            r_addr    <= (r_dir == DIR_UP) ? r_addr + 1'b1 : r_addr - 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_RPT;
            r_stepped <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_stepped <= 1'b0;
    end else begin
      r_stepped <= 1'b0;
      if (w_inc_rise && !dec) begin
        r_addr    <= r_addr + 1'b1;
        r_stepped <= 1'b1;
      end else if (w_dec_rise && !inc) begin
        r_addr    <= r_addr - 1'b1;
        r_stepped <= 1'b1;
      end
    end
  end
`endif

  // r_stepped marks the cycle addr shows its new value; the flag follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_addr_chg <= 1'b0;
    else      r_addr_chg <= r_stepped;
  end

  assign cpu_en   = r_cpu_en;
  assign addr     = r_addr;
  assign addr_chg = r_addr_chg;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl: vector table plus hand-written hold/reset/conflict sequences.
module tb_btn_step_ctrl;

  logic       clk;
  logic       rst;
  logic       run, step, inc, dec;
  logic       cpu_en;
  logic [7:0] addr;
  logic       addr_chg;

  int n_chk  = 0;
  int n_fail = 0;
  int chg_cnt = 0;
  int base;

  typedef struct {
    logic       run, step, inc, dec;
    logic       exp_en;
    logic [7:0] exp_addr;
    logic       exp_chg;
  } vec_t;

  vec_t tv[24];

  btn_step_ctrl #(.AW(8), .HOLD(4), .RPT(2)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .inc(inc), .dec(dec),
    .cpu_en(cpu_en), .addr(addr), .addr_chg(addr_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (addr_chg === 1'b1) chg_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // run step inc dec | cpu_en addr addr_chg
    tv[0]  = '{0,0,0,0, 0,  0,0};
    tv[1]  = '{0,1,0,0, 1,  0,0};
    tv[2]  = '{0,1,0,0, 0,  0,0};
    tv[3]  = '{0,1,0,0, 0,  0,0};
    tv[4]  = '{0,1,0,0, 0,  0,0};
    tv[5]  = '{0,1,0,0, 0,  0,0};
    tv[6]  = '{0,0,0,0, 0,  0,0};
    tv[7]  = '{1,0,0,0, 1,  0,0};
    tv[8]  = '{1,1,0,0, 1,  0,0};
    tv[9]  = '{1,0,0,0, 1,  0,0};
    tv[10] = '{0,0,0,0, 0,  0,0};
    tv[11] = '{0,0,0,1, 0,255,0};
    tv[12] = '{0,0,0,1, 0,255,1};
    tv[13] = '{0,0,0,0, 0,255,0};
    tv[14] = '{0,0,1,0, 0,  0,0};
    tv[15] = '{0,0,0,0, 0,  0,1};
    tv[16] = '{0,0,1,1, 0,  0,0};
    tv[17] = '{0,0,0,0, 0,  0,0};
    tv[18] = '{0,1,1,0, 1,  1,0};
    tv[19] = '{0,0,0,0, 0,  1,1};
    tv[20] = '{0,0,0,1, 0,  0,0};
    tv[21] = '{0,0,1,1, 0,  0,1};
    tv[22] = '{0,0,1,0, 0,  0,0};
    tv[23] = '{0,0,0,0, 0,  0,0};

    rst = 1'b0; run = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0;
    cyc();
    check("reset_cpu_en", cpu_en, 0);
    check("reset_addr", addr, 0);
    check("reset_addr_chg", addr_chg, 0);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run = tv[i].run; step = tv[i].step; inc = tv[i].inc; dec = tv[i].dec;
      cyc();
      check($sformatf("vec%0d_cpu_en", i), cpu_en, tv[i].exp_en);
      check($sformatf("vec%0d_addr", i), addr, tv[i].exp_addr);
      check($sformatf("vec%0d_addr_chg", i), addr_chg, tv[i].exp_chg);
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Auto-repeat: steps at edge, edge+4, then every 2 cycles while held.
    base = chg_cnt;
    inc = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("rpt_addr_k%0d", k), addr,
            1 + int'(k >= 4) + int'(k >= 6) + int'(k >= 8) + int'(k >= 10));
    end
    inc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rpt_release_addr", addr, 5);
    end
    check("rpt_chg_pulses", chg_cnt - base, 5);

    // Reset while in RPT at addr 7, run mode active.
    run = 1'b1;
    inc = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    check("pre_rst_addr", addr, 7);
    check("pre_rst_cpu_en", cpu_en, 1);
    rst = 1'b0;
    #1;
    check("async_rst_addr", addr, 0);
    check("async_rst_cpu_en", cpu_en, 0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_cpu_en", cpu_en, 1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("held_after_rst_addr", addr, 0);
    end
    inc = 1'b0;
    cyc();
    cyc();
    inc = 1'b1;
    cyc();
    check("repress_addr", addr, 1);

    // Conflict: dec asserted while inc repeating freezes addr.
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("conf_hold_addr", addr, (k == 4) ? 2 : 1);
    end
    dec = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("conf_both_addr", addr, 2);
    end
    dec = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("conf_dec_rel_addr", addr, 2);
    end
    inc = 1'b0;
    cyc();
    inc = 1'b1; dec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("same_rise_addr", addr, 2);
    end
    inc = 1'b0; dec = 1'b0; run = 1'b0;
    cyc();
`else
    // Without auto-repeat a long hold yields exactly one step.
    base = chg_cnt;
    inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("hold20_addr", addr, 1);
    end
    inc = 1'b0;
    cyc();
    cyc();
    check("hold20_chg_pulses", chg_cnt - base, 1);

    // Reset with a button held: no step until released and pressed again.
    run = 1'b1;
    inc = 1'b1;
    cyc();
    check("pre_rst_addr", addr, 2);
    check("pre_rst_cpu_en", cpu_en, 1);
    rst = 1'b0;
    #1;
    check("async_rst_addr", addr, 0);
    check("async_rst_cpu_en", cpu_en, 0);
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_cpu_en", cpu_en, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("held_after_rst_addr", addr, 0);
    end
    inc = 1'b0;
    cyc();
    inc = 1'b1;
    cyc();
    check("repress_addr", addr, 1);

    // Conflict: dec rising while inc held, then inc released with dec held.
    dec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("conf_both_addr", addr, 1);
    end
    inc = 1'b0;
    cyc();
    check("conf_inc_rel_addr", addr, 1);
    dec = 1'b0; run = 1'b0;
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
